// File: rtl/switch_box_cfg_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : switch_box_cfg_pkg                                       |
// | Description : Shared types, constants and sizing helpers for the CLB   |
// |               switch box configuration loader.                         |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
package switch_box_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } state_e;

  // Mux-select code that no switch box mux may be programmed with.
  localparam logic [1:0] SEL_ILLEGAL = 2'b11;

  // Total configuration bits: 8 per single-length track, 8 per pair of
  // double-length tracks.
  function automatic int cfg_width(input int ws, input int wd);
    return ws * 8 + (wd / 2) * 8;
  endfunction

  // Words needed to carry cw bits in dw-bit words (rounded up).
  function automatic int cfg_words(input int cw, input int dw);
    return (cw + dw - 1) / dw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sb_cfg_field_check.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : sb_cfg_field_check                                       |
// | Description : Combinational scan of every 2-bit mux-select field of a  |
// |               configuration image; flags any illegal code.             |
// | Ports       : shadow [CW-1:0] in  - configuration image to inspect     |
// |               bad             out - high if any field is illegal       |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module sb_cfg_field_check
  import switch_box_cfg_pkg::*;
#(
  parameter int CW = 80
) (
  input  logic [CW-1:0] shadow,
  output logic          bad
);

  localparam int c_NFIELDS = CW / 2;

  logic [c_NFIELDS-1:0] w_hit;

  generate
    for (genvar i = 0; i < c_NFIELDS; i++) begin : g_field
      assign w_hit[i] = (shadow[2*i +: 2] == SEL_ILLEGAL);
    end
  endgenerate

  assign bad = |w_hit;

endmodule
`default_nettype wire

// File: rtl/switch_box_config_loader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : switch_box_config_loader                                 |
// | Description : Streams a configuration into a shadow register, checks   |
// |               every mux-select field, then commits the whole image to  |
// |               the switch box in one edge (or rejects it).              |
// | Ports       : clk, rst (async, active-high)                            |
// |               start, abort         - load control                      |
// |               cfg_data/valid/ready - word stream handshake             |
// |               c [CW-1:0]           - active configuration              |
// |               busy, done, err      - status (done/err one-cycle)       |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module switch_box_config_loader
  import switch_box_cfg_pkg::*;
#(
  parameter  int WS     = 7,
  parameter  int WD     = 6,
  parameter  int DW     = 8,
  localparam int CW     = cfg_width(WS, WD),
  localparam int NWORDS = cfg_words(CW, DW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] cfg_data,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  output logic [CW-1:0] c,
  output logic          busy,
  output logic          done,
  output logic          err
);

  // Shadow is a whole number of words wide; bits above CW-1 absorb padding.
  localparam int SW    = NWORDS * DW;
  localparam int CNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] c_LAST_WORD = CNT_W'(NWORDS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    shadow_q, shadow_d;
  logic [CW-1:0]    c_q, c_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             w_bad;

  sb_cfg_field_check #(
    .CW (CW)
  ) u_field_check (
    .shadow (shadow_q[CW-1:0]),
    .bad    (w_bad)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      c_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      c_q      <= c_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    c_d      = c_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        // Abort wins over a word presented in the same cycle.
        if (abort) begin
          state_d = IDLE;
        end else if (cfg_valid) begin
          for (int k = 0; k < NWORDS; k++) begin
            if (cnt_q == CNT_W'(k)) shadow_d[k*DW +: DW] = cfg_data;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == c_LAST_WORD) state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (w_bad) begin
          err_d = 1'b1;
        end else begin
          c_d    = shadow_q[CW-1:0];
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg_ready = (state_q == LOAD);
  assign busy      = (state_q != IDLE);
  assign c         = c_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_box_config_loader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_switch_box_config_loader                              |
// | Description : Directed, table-driven self-checking bench for the       |
// |               switch box configuration loader (DW=8 and DW=16).        |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_switch_box_config_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, abort = 1'b0, cfg_valid = 1'b0;
  logic [7:0]  cfg_data = '0;
  logic        cfg_ready, busy, done, err;
  logic [79:0] c;

  logic        start2 = 1'b0, abort2 = 1'b0, cfg_valid2 = 1'b0;
  logic [15:0] cfg_data2 = '0;
  logic        cfg_ready2, busy2, done2, err2;
  logic [79:0] c2;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  switch_box_config_loader #(.WS(7), .WD(6), .DW(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .c(c), .busy(busy), .done(done), .err(err)
  );

  switch_box_config_loader #(.WS(7), .WD(6), .DW(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2),
    .cfg_data(cfg_data2), .cfg_valid(cfg_valid2), .cfg_ready(cfg_ready2),
    .c(c2), .busy(busy2), .done(done2), .err(err2)
  );

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic send_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d, input bit gap);
    if (gap) begin
      cfg_valid = 1'b0;
      @(negedge clk);
    end
    cfg_valid = 1'b1;
    cfg_data  = d;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  typedef struct {
    int          idx;
    logic [7:0]  val;
    bit          gaps;
    bit          exp_err;
    logic [79:0] exp_c;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{0, 8'h09, 1'b0, 1'b0, 80'h00000000000000000009};
    tbl[1] = '{0, 8'h09, 1'b1, 1'b0, 80'h00000000000000000009};
    tbl[2] = '{3, 8'h30, 1'b0, 1'b1, 80'h00000000000000000009};
    tbl[3] = '{9, 8'hFF, 1'b0, 1'b1, 80'h00000000000000000009};
    tbl[4] = '{5, 8'hA5, 1'b1, 1'b0, 80'h00000000A50000000000};
    tbl[5] = '{2, 8'h0C, 1'b0, 1'b1, 80'h00000000A50000000000};
    tbl[6] = '{9, 8'h40, 1'b0, 1'b0, 80'h40000000000000000000};

    // Asynchronous reset asserted mid-cycle, before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_c", c, 80'h0);
    chk("rst_busy", {79'h0, busy}, 80'h0);
    chk("rst_done_err", {78'h0, done, err}, 80'h0);
    @(negedge clk); rst = 1'b0;

    // Idle ignores valid words without a start.
    cfg_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", {79'h0, cfg_ready}, 80'h0);
    chk("idle_busy", {79'h0, busy}, 80'h0);
    cfg_valid = 1'b0;

    // start together with abort stays idle.
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", {79'h0, busy}, 80'h0);

    for (int v = 0; v < 7; v++) begin
      send_start();
      chk($sformatf("v%0d_ready", v), {79'h0, cfg_ready}, 80'h1);
      for (int k = 0; k < 10; k++)
        send_word((k == tbl[v].idx) ? tbl[v].val : 8'h00, tbl[v].gaps);
      // One cycle of CHECK after the last accept.
      chk($sformatf("v%0d_check_busy", v), {79'h0, busy}, 80'h1);
      chk($sformatf("v%0d_check_flags", v), {78'h0, done, err}, 80'h0);
      @(negedge clk);
      chk($sformatf("v%0d_done", v), {79'h0, done}, {79'h0, !tbl[v].exp_err});
      chk($sformatf("v%0d_err", v), {79'h0, err}, {79'h0, tbl[v].exp_err});
      chk($sformatf("v%0d_c", v), c, tbl[v].exp_c);
      chk($sformatf("v%0d_busy_low", v), {79'h0, busy}, 80'h0);
      @(negedge clk);
      chk($sformatf("v%0d_pulse", v), {78'h0, done, err}, 80'h0);
    end

    // Abort after four words with a word presented in the same cycle.
    send_start();
    for (int k = 0; k < 4; k++) send_word(8'h05, 1'b0);
    cfg_valid = 1'b1; cfg_data = 8'h05; abort = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; abort = 1'b0;
    chk("abort_idle", {78'h0, busy, cfg_ready}, 80'h0);
    chk("abort_c", c, 80'h40000000000000000000);
    @(negedge clk);
    chk("abort_flags", {78'h0, done, err}, 80'h0);

    // Abort on the final word must beat its acceptance.
    send_start();
    for (int k = 0; k < 9; k++) send_word(8'h00, 1'b0);
    cfg_valid = 1'b1; cfg_data = 8'h00; abort = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; abort = 1'b0;
    chk("abort_last_busy", {79'h0, busy}, 80'h0);
    repeat (2) @(negedge clk);
    chk("abort_last_flags", {78'h0, done, err}, 80'h0);
    chk("abort_last_c", c, 80'h40000000000000000000);

    // A normal load after aborts.
    send_start();
    for (int k = 0; k < 10; k++) send_word((k == 0) ? 8'h09 : 8'h00, 1'b0);
    @(negedge clk);
    chk("post_abort_done", {79'h0, done}, 80'h1);
    chk("post_abort_c", c, 80'h00000000000000000009);

    // 16-bit word variant: five words, last one 16'h0000.
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cfg_valid2 = 1'b1;
      cfg_data2  = (k == 0) ? 16'h0009 : 16'h0000;
      @(negedge clk);
    end
    cfg_valid2 = 1'b0;
    chk("dw16_check_busy", {79'h0, busy2}, 80'h1);
    @(negedge clk);
    chk("dw16_done", {78'h0, done2, err2}, 80'h2);
    chk("dw16_c", c2, 80'h00000000000000000009);

    // Reset asserted mid-cycle while word 2 is presented.
    send_start();
    for (int k = 0; k < 2; k++) send_word(8'h01, 1'b0);
    cfg_valid = 1'b1; cfg_data = 8'h01;
    #2 rst = 1'b1;
    #1;
    chk("midload_rst_c", c, 80'h0);
    chk("midload_rst_state", {78'h0, busy, cfg_ready}, 80'h0);
    @(negedge clk); rst = 1'b0; cfg_valid = 1'b0;
    @(negedge clk);
    chk("midload_rst_idle", {77'h0, busy, done, err}, 80'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
